// File: rtl/lcd4_sequencer_pkg.sv
// Shared definitions for the 4-bit HD44780 sequencer: state encodings,
// LCD command codes and the power-on init step table.
package lcd4_sequencer_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    LOAD,
    NIB_XFER,
    NIB_GAP,
    POST_WAIT
  } seq_state_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    NIB_SETUP,
    NIB_EHI,
    NIB_HOLD
  } stb_state_t;

  typedef enum logic [1:0] {
    DLY_INIT1,
    DLY_INIT2,
    DLY_CMD,
    DLY_CLEAR
  } dly_sel_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;
  localparam logic [7:0] CMD_FUNCSET  = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISPON   = 8'h0C;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
  localparam logic [2:0] INIT_LAST     = 3'd7;

  typedef struct packed {
    logic       nib_only;
    logic [7:0] data;
    dly_sel_t   dly;
  } init_step_t;

  // Nibble-only steps carry their nibble in the upper half of data.
  function automatic init_step_t init_step(input logic [2:0] idx);
    init_step_t s;
    case (idx)
      3'd0:    s = '{nib_only: 1'b1, data: {INIT_NIB_8BIT, 4'h0}, dly: DLY_INIT1};
      3'd1:    s = '{nib_only: 1'b1, data: {INIT_NIB_8BIT, 4'h0}, dly: DLY_INIT2};
      3'd2:    s = '{nib_only: 1'b1, data: {INIT_NIB_8BIT, 4'h0}, dly: DLY_CMD};
      3'd3:    s = '{nib_only: 1'b1, data: {INIT_NIB_4BIT, 4'h0}, dly: DLY_CMD};
      3'd4:    s = '{nib_only: 1'b0, data: CMD_FUNCSET, dly: DLY_CMD};
      3'd5:    s = '{nib_only: 1'b0, data: CMD_ENTRY, dly: DLY_CMD};
      3'd6:    s = '{nib_only: 1'b0, data: CMD_DISPON, dly: DLY_CMD};
      default: s = '{nib_only: 1'b0, data: CMD_CLEAR, dly: DLY_CLEAR};
    endcase
    return s;
  endfunction

  // Clear and return-home need the long execution time.
  function automatic dly_sel_t byte_dly(input logic rs, input logic [7:0] data);
    if (!rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT))
      return DLY_CLEAR;
    return DLY_CMD;
  endfunction

endpackage

// File: rtl/lcd4_strobe.sv
// One-nibble LCD write: data/RS setup, E high pulse, data hold, then a
// single-cycle done pulse during the last hold cycle.
module lcd4_strobe
  import lcd4_sequencer_pkg::*;
#(
  parameter int CNT_W   = 20,
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 12,
  parameter int T_HOLD  = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       done
);

  stb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             e_nxt;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= STB_IDLE;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lcd_e <= e_nxt;
      if (start && state == STB_IDLE) begin
        lcd_data <= nib;
        lcd_rs   <= rs;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STB_IDLE:
        if (start) begin
          state_nxt = NIB_SETUP;
          cnt_nxt   = CNT_W'(T_SETUP - 1);
        end
      NIB_SETUP:
        if (cnt == '0) begin
          state_nxt = NIB_EHI;
          cnt_nxt   = CNT_W'(T_EPW - 1);
        end else cnt_nxt = cnt - CNT_W'(1);
      NIB_EHI:
        if (cnt == '0) begin
          state_nxt = NIB_HOLD;
          cnt_nxt   = CNT_W'(T_HOLD - 1);
        end else cnt_nxt = cnt - CNT_W'(1);
      default:
        if (cnt == '0) state_nxt = STB_IDLE;
        else cnt_nxt = cnt - CNT_W'(1);
    endcase
  end

  // E is registered from the next state so it is high exactly while in NIB_EHI.
  always_comb begin
    e_nxt = (state_nxt == NIB_EHI);
    done  = (state == NIB_HOLD) && (cnt == '0);
  end

endmodule

// File: rtl/lcd4_sequencer.sv
// HD44780 4-bit sequencer: autonomous power-on init, then byte writes over
// valid/ready, each split into two strobed nibbles plus a post-byte delay.
module lcd4_sequencer
  import lcd4_sequencer_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int T_POWERON = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_NIBBLE  = 50,
  parameter int T_SETUP   = 2,
  parameter int T_EPW     = 12,
  parameter int T_HOLD    = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_E,
  output logic       oInitDone,
  output logic       oBusy
);

  if (T_POWERON < 1 || T_INIT1 < 1 || T_INIT2 < 1 || T_CMD < 1 || T_CLEAR < 1 ||
      T_NIBBLE < 1 || T_SETUP < 1 || T_EPW < 1 || T_HOLD < 1) begin : g_zero_t
    $error("lcd4_sequencer: every T_* phase length must be at least 1");
  end
  if (T_POWERON > 2**CNT_W || T_INIT1 > 2**CNT_W || T_CLEAR > 2**CNT_W ||
      T_CMD > 2**CNT_W || T_EPW > 2**CNT_W) begin : g_cnt_w
    $error("lcd4_sequencer: CNT_W too narrow for the T_* values");
  end

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       step, step_sel;
  logic             lo_r, issue_step, init_fin, accept;
  logic [7:0]       byte_r;
  logic             rs_r, nib_only_r;
  dly_sel_t         dly_r;
  init_step_t       cur_step;
  logic             strb_start, strb_rs, strb_done, ready_nxt;
  logic [3:0]       strb_nib;

  function automatic logic [CNT_W-1:0] dly_cnt(input dly_sel_t sel);
    case (sel)
      DLY_INIT1: dly_cnt = CNT_W'(T_INIT1 - 1);
      DLY_INIT2: dly_cnt = CNT_W'(T_INIT2 - 1);
      DLY_CLEAR: dly_cnt = CNT_W'(T_CLEAR - 1);
      default:   dly_cnt = CNT_W'(T_CMD - 1);
    endcase
  endfunction

  assign accept   = (state == IDLE) && iValid && oReady;
  assign cur_step = init_step(step_sel);
  assign oLCD_RW  = 1'b0;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      step      <= '0;
      lo_r      <= 1'b0;
      oReady    <= 1'b0;
      oBusy     <= 1'b1;
      oInitDone <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      oReady <= ready_nxt;
      oBusy  <= !ready_nxt;
      if (issue_step) step <= step_sel;
      if (init_fin) oInitDone <= 1'b1;
      if (issue_step || state == LOAD) lo_r <= 1'b0;
      else if (state == NIB_GAP && cnt == '0) lo_r <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (issue_step) begin
      byte_r     <= cur_step.data;
      rs_r       <= 1'b0;
      nib_only_r <= cur_step.nib_only;
      dly_r      <= cur_step.dly;
    end else if (accept) begin
      byte_r     <= iData;
      rs_r       <= iRS;
      nib_only_r <= 1'b0;
      dly_r      <= byte_dly(iRS, iData);
    end
  end

  // Power-on wait counts up from the reset value; all other phases count down.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    issue_step = 1'b0;
    init_fin   = 1'b0;
    step_sel   = step;
    case (state)
      PWR_WAIT:
        if (cnt == CNT_W'(T_POWERON - 1)) begin
          state_nxt  = NIB_XFER;
          issue_step = 1'b1;
          step_sel   = 3'd0;
        end else cnt_nxt = cnt + CNT_W'(1);
      IDLE:
        if (accept) state_nxt = LOAD;
      LOAD:
        state_nxt = NIB_XFER;
      NIB_XFER:
        if (strb_done) begin
          if (lo_r || nib_only_r) begin
            state_nxt = POST_WAIT;
            cnt_nxt   = dly_cnt(dly_r);
          end else begin
            state_nxt = NIB_GAP;
            cnt_nxt   = CNT_W'(T_NIBBLE - 1);
          end
        end
      NIB_GAP:
        if (cnt == '0) state_nxt = NIB_XFER;
        else cnt_nxt = cnt - CNT_W'(1);
      POST_WAIT:
        if (cnt == '0) begin
          if (!oInitDone && step != INIT_LAST) begin
            state_nxt  = NIB_XFER;
            issue_step = 1'b1;
            step_sel   = step + 3'd1;
          end else begin
            state_nxt = IDLE;
            init_fin  = !oInitDone;
          end
        end else cnt_nxt = cnt - CNT_W'(1);
      default:
        state_nxt = PWR_WAIT;
    endcase
  end

  // Strobe starts are issued in the last cycle of the preceding phase.
  always_comb begin
    strb_start = 1'b0;
    strb_nib   = byte_r[7:4];
    strb_rs    = rs_r;
    if (issue_step) begin
      strb_start = 1'b1;
      strb_nib   = cur_step.data[7:4];
      strb_rs    = 1'b0;
    end else if (state == LOAD) begin
      strb_start = 1'b1;
    end else if (state == NIB_GAP && cnt == '0) begin
      strb_start = 1'b1;
      strb_nib   = byte_r[3:0];
    end
    ready_nxt = (state_nxt == IDLE);
  end

  lcd4_strobe #(
    .CNT_W  (CNT_W),
    .T_SETUP(T_SETUP),
    .T_EPW  (T_EPW),
    .T_HOLD (T_HOLD)
  ) u_strobe (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (strb_start),
    .nib     (strb_nib),
    .rs      (strb_rs),
    .lcd_data(oLCD_Data),
    .lcd_rs  (oLCD_RS),
    .lcd_e   (oLCD_E),
    .done    (strb_done)
  );

endmodule

// File: tb/tb_lcd4_sequencer.sv
// Directed bench for lcd4_sequencer with short timing parameters: init
// sequence, byte writes, back-to-back, early valid and reset abort.
module tb_lcd4_sequencer;

  localparam int CNT_W = 8;

  logic       Clock, Reset, iValid, iRS;
  logic [7:0] iData;
  logic       oReady, oLCD_RS, oLCD_RW, oLCD_E, oInitDone, oBusy;
  logic [3:0] oLCD_Data;

  int tests = 0, failed = 0, cyc = 0;
  int rise_q[$], nib_q[$], rs_q[$], w_q[$];
  int hi_cnt = 0, early_rdy = 0, e_glitch = 0;
  logic e_prev = 1'b0;
  logic [3:0] d_at_rise = '0;

  lcd4_sequencer #(
    .CNT_W(CNT_W), .T_POWERON(20), .T_INIT1(15), .T_INIT2(8), .T_CMD(10),
    .T_CLEAR(30), .T_NIBBLE(4), .T_SETUP(2), .T_EPW(3), .T_HOLD(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady), .iRS(iRS),
    .iData(iData), .oLCD_Data(oLCD_Data), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
    .oLCD_E(oLCD_E), .oInitDone(oInitDone), .oBusy(oBusy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // E-pulse recorder, sampled 1 time unit after each rising edge
  always @(posedge Clock) begin
    #1;
    if (oLCD_E && !e_prev) begin
      rise_q.push_back(cyc);
      nib_q.push_back(int'(oLCD_Data));
      rs_q.push_back(int'(oLCD_RS));
      d_at_rise = oLCD_Data;
      hi_cnt = 1;
    end else if (oLCD_E) begin
      hi_cnt++;
      if (oLCD_Data !== d_at_rise) e_glitch++;
    end
    if (!oLCD_E && e_prev) w_q.push_back(hi_cnt);
    if (oReady && !oInitDone) early_rdy++;
    e_prev = oLCD_E;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_init(input string tag, input int c0, input int base);
    int exp_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
    int exp_rel[12] = '{22, 43, 57, 73, 89, 99, 115, 125, 141, 151, 167, 177};
    chk($sformatf("%s_npulses", tag), rise_q.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < rise_q.size() && base + i < w_q.size()) begin
        chk($sformatf("%s_rise%0d", tag, i), rise_q[base+i] - c0, exp_rel[i]);
        chk($sformatf("%s_nib%0d", tag, i), nib_q[base+i], exp_nib[i]);
        chk($sformatf("%s_rs%0d", tag, i), rs_q[base+i], 0);
        chk($sformatf("%s_epw%0d", tag, i), w_q[base+i], 3);
      end
    end
  endtask

  task automatic chk_byte(input string tag, input int base, input int acc,
                          input int hi, input int lo, input int rs);
    chk({tag, "_present"}, int'(rise_q.size() >= base + 2 && w_q.size() >= base + 2), 1);
    if (rise_q.size() >= base + 2 && w_q.size() >= base + 2) begin
      chk({tag, "_rise_hi"}, rise_q[base] - acc, 3);
      chk({tag, "_rise_lo"}, rise_q[base+1] - acc, 13);
      chk({tag, "_nib_hi"}, nib_q[base], hi);
      chk({tag, "_nib_lo"}, nib_q[base+1], lo);
      chk({tag, "_rs_hi"}, rs_q[base], rs);
      chk({tag, "_rs_lo"}, rs_q[base+1], rs);
      chk({tag, "_epw_hi"}, w_q[base], 3);
      chk({tag, "_epw_lo"}, w_q[base+1], 3);
    end
  endtask

  task automatic wait_ready(input string tag, input int acc, input int lat);
    int n = 0;
    while (!oReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk(tag, cyc - acc, lat);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!oInitDone && n < 500) begin
      @(negedge Clock);
      n++;
    end
  endtask

  initial begin
    int c0, base, acc, acc1, acc2, n;
    Reset = 1'b0; iValid = 1'b0; iRS = 1'b0; iData = 8'h00;
    repeat (3) @(negedge Clock);

    // Reset state
    chk("rst_data", int'(oLCD_Data), 0);
    chk("rst_rs", int'(oLCD_RS), 0);
    chk("rst_rw", int'(oLCD_RW), 0);
    chk("rst_e", int'(oLCD_E), 0);
    chk("rst_ready", int'(oReady), 0);
    chk("rst_initdone", int'(oInitDone), 0);
    chk("rst_busy", int'(oBusy), 1);

    // 1: power-on init
    c0 = cyc; base = rise_q.size();
    Reset = 1'b1;
    wait_init();
    chk("s1_initdone", int'(oInitDone), 1);
    chk("s1_done_time", cyc - c0, 211);
    chk("s1_ready", int'(oReady), 1);
    chk("s1_busy", int'(oBusy), 0);
    check_init("s1", c0, base);

    // 2: character 0x48
    base = rise_q.size();
    iValid = 1'b1; iRS = 1'b1; iData = 8'h48;
    @(negedge Clock);
    acc = cyc; iValid = 1'b0; iRS = 1'b0; iData = 8'hFF;
    chk("s2_ready_drop", int'(oReady), 0);
    chk("s2_busy", int'(oBusy), 1);
    wait_ready("s2_latency", acc, 27);
    chk("s2_npulses", rise_q.size() - base, 2);
    chk_byte("s2", base, acc, 4, 8, 1);

    // 3: clear command
    base = rise_q.size();
    iValid = 1'b1; iRS = 1'b0; iData = 8'h01;
    @(negedge Clock);
    acc = cyc; iValid = 1'b0; iData = 8'h00;
    wait_ready("s3_latency", acc, 47);
    chk("s3_npulses", rise_q.size() - base, 2);
    chk_byte("s3", base, acc, 0, 1, 0);

    // 4: back-to-back, iData changes while the first byte is in flight
    base = rise_q.size();
    iValid = 1'b1; iRS = 1'b1; iData = 8'h41;
    @(negedge Clock);
    acc1 = cyc; iData = 8'h42;
    chk("s4_ready_drop", int'(oReady), 0);
    wait_ready("s4_latency1", acc1, 27);
    @(negedge Clock);
    acc2 = cyc; iValid = 1'b0;
    chk("s4_b2b_accept", acc2 - acc1, 28);
    chk("s4_ready_drop2", int'(oReady), 0);
    wait_ready("s4_latency2", acc2, 27);
    chk("s4_npulses", rise_q.size() - base, 4);
    chk_byte("s4a", base, acc1, 4, 1, 1);
    chk_byte("s4b", base + 2, acc2, 4, 2, 1);
    if (rise_q.size() >= base + 3)
      chk("s4_sep", rise_q[base+2] - rise_q[base+1], 18);

    // 6: reset during E high of a write
    iValid = 1'b1; iRS = 1'b1; iData = 8'h37;
    @(negedge Clock);
    iValid = 1'b0;
    n = 0;
    while (!oLCD_E && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("s6_in_ehi", int'(oLCD_E), 1);
    chk("s6_data_before", int'(oLCD_Data), 3);
    Reset = 1'b0;
    @(negedge Clock);
    chk("s6_rst_e", int'(oLCD_E), 0);
    chk("s6_rst_data", int'(oLCD_Data), 0);
    chk("s6_rst_initdone", int'(oInitDone), 0);
    chk("s6_rst_busy", int'(oBusy), 1);
    chk("s6_rst_ready", int'(oReady), 0);
    @(negedge Clock);

    // 5: valid already held while the repeated init runs
    c0 = cyc; base = rise_q.size(); early_rdy = 0;
    Reset = 1'b1; iValid = 1'b1; iRS = 1'b1; iData = 8'h5A;
    wait_init();
    chk("s6_initdone", int'(oInitDone), 1);
    chk("s6_done_time", cyc - c0, 211);
    chk("s5_no_early_ready", early_rdy, 0);
    check_init("s6", c0, base);
    base = rise_q.size();
    @(negedge Clock);
    acc = cyc; iValid = 1'b0;
    chk("s5_accept", acc - c0, 212);
    chk("s5_ready_drop", int'(oReady), 0);
    wait_ready("s5_latency", acc, 27);
    chk("s5_npulses", rise_q.size() - base, 2);
    chk_byte("s5", base, acc, 5, 10, 1);
    chk("data_stable_during_e", e_glitch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
